// File: rtl/emin_sweep_ctrl.sv
// Emin sweep sequencer: launches one emin pass per frame i, writes Emin(j,i) to the matrix buffer and reports the per-frame minimum.
// Optional cycle counter output sweep_cycles_out is enabled by defining EMIN_SWEEP_PERF_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start_in; stray results are dropped
//   S_LAUNCH | one-cycle launch strobe to emin for frame i_cnt
//   S_WAIT   | accepting results j = 0..i_cnt, watchdog running
//   S_NEXT   | best pulse cycle; gives emin time to return to its start state
module emin_sweep_ctrl #(
    parameter int BIT_WIDTH      = 32,
    parameter int I              = 160,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          error_out,
    output logic [$clog2(I)-1:0]          emin_i_out,
    output logic                          emin_valid_out,
    input  logic [$clog2(I)-1:0]          emin_j_in,
    input  logic signed [BIT_WIDTH-1:0]   emin_data_in,
    input  logic                          emin_valid_in,
    output logic                          wr_en_out,
    output logic [$clog2(I*I)-1:0]        wr_addr_out,
    output logic [BIT_WIDTH-1:0]          wr_data_out,
    output logic                          best_valid_out,
    output logic [$clog2(I)-1:0]          best_i_out,
    output logic [$clog2(I)-1:0]          best_j_out,
    output logic signed [BIT_WIDTH-1:0]   best_val_out
`ifdef EMIN_SWEEP_PERF_EN
   ,output logic [31:0]                   sweep_cycles_out
`endif
);

    localparam int IW  = $clog2(I);
    localparam int AW  = $clog2(I*I);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic signed [BIT_WIDTH-1:0] MAX_VAL  = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [IW-1:0]               LAST_I   = IW'(I - 1);
    localparam logic [AW-1:0]               I_AW     = AW'(I);
    localparam logic [WDW-1:0]              WD_LIMIT = WDW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_NEXT} state_t;

    state_t r_state, w_state_nxt;

    logic [IW-1:0]                 r_i_cnt;
    logic [IW-1:0]                 r_exp_j;
    logic [WDW-1:0]                r_wdog;
    logic signed [BIT_WIDTH-1:0]   r_min_val;
    logic [IW-1:0]                 r_min_j;
    logic                          r_wr_en;
    logic [AW-1:0]                 r_wr_addr;
    logic [BIT_WIDTH-1:0]          r_wr_data;
    logic                          r_best_valid;
    logic [IW-1:0]                 r_best_i;
    logic [IW-1:0]                 r_best_j;
    logic signed [BIT_WIDTH-1:0]   r_best_val;
    logic                          r_done;
    logic                          r_error;

    logic            w_start_ok;
    logic            w_beat_ok;
    logic            w_bad_j;
    logic            w_timeout;
    logic            w_last;
    logic            w_new_min;
    logic [WDW-1:0]  w_wdog_inc;
    logic [AW-1:0]   w_wr_addr;

    assign w_wr_addr  = AW'(r_i_cnt) * I_AW + AW'(r_exp_j);
    assign w_wdog_inc = r_wdog + 1'b1;
    // Strict less-than keeps the earliest j on ties.
    assign w_new_min  = (emin_data_in < r_min_val);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_beat_ok   = 1'b0;
        w_bad_j     = 1'b0;
        w_timeout   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (emin_valid_in) begin
                    if (emin_j_in != r_exp_j) begin
                        w_bad_j     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_beat_ok = 1'b1;
                        if (r_exp_j == r_i_cnt) begin
                            w_last      = 1'b1;
                            w_state_nxt = (r_i_cnt == LAST_I) ? S_IDLE : S_NEXT;
                        end
                    end
                end else if (w_wdog_inc == WD_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_NEXT:  w_state_nxt = S_LAUNCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_i_cnt      <= '0;
            r_exp_j      <= '0;
            r_wdog       <= '0;
            r_min_val    <= '0;
            r_min_j      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_best_valid <= 1'b0;
            r_best_i     <= '0;
            r_best_j     <= '0;
            r_best_val   <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_wr_en      <= w_beat_ok;
            r_best_valid <= w_last;
            r_done       <= w_last && (r_i_cnt == LAST_I);

            if (w_start_ok) begin
                r_error <= 1'b0;
                r_i_cnt <= '0;
            end
            if (w_bad_j || w_timeout) begin
                r_error <= 1'b1;
            end
            if (r_state == S_NEXT) begin
                r_i_cnt <= r_i_cnt + 1'b1;
            end

            if (r_state == S_LAUNCH) begin
                r_exp_j   <= '0;
                r_min_val <= MAX_VAL;
                r_min_j   <= '0;
                r_wdog    <= '0;
            end else if (r_state == S_WAIT && !emin_valid_in) begin
                r_wdog <= w_wdog_inc;
            end

            if (w_beat_ok) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= emin_data_in;
                r_exp_j   <= r_exp_j + 1'b1;
                r_wdog    <= '0;
                if (w_new_min) begin
                    r_min_val <= emin_data_in;
                    r_min_j   <= emin_j_in;
                end
            end

            // Fold the final beat into the reported minimum directly.
            if (w_last) begin
                r_best_i   <= r_i_cnt;
                r_best_j   <= w_new_min ? emin_j_in : r_min_j;
                r_best_val <= w_new_min ? emin_data_in : r_min_val;
            end
        end
    end

`ifdef EMIN_SWEEP_PERF_EN
    logic [31:0] r_sweep_cycles;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sweep_cycles <= '0;
        end else if (w_start_ok) begin
            r_sweep_cycles <= '0;
        end else if (r_state != S_IDLE && r_sweep_cycles != 32'hFFFF_FFFF) begin
            r_sweep_cycles <= r_sweep_cycles + 32'd1;
        end
    end

    assign sweep_cycles_out = r_sweep_cycles;
`endif

    assign busy_out       = (r_state != S_IDLE);
    assign emin_valid_out = (r_state == S_LAUNCH);
    assign emin_i_out     = r_i_cnt;
    assign done_out       = r_done;
    assign error_out      = r_error;
    assign wr_en_out      = r_wr_en;
    assign wr_addr_out    = r_wr_addr;
    assign wr_data_out    = r_wr_data;
    assign best_valid_out = r_best_valid;
    assign best_i_out     = r_best_i;
    assign best_j_out     = r_best_j;
    assign best_val_out   = r_best_val;

endmodule
